// File: rtl/nvdla_softmax_sched.sv
// Round-robin job scheduler sharing one softmax engine among NUM_REQ heads.
// Validates row length, launches, supervises done/error/timeout, responds.
module nvdla_softmax_sched #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 32,
  parameter int MAX_LEN = 256,
  parameter int TIMEOUT = 60000,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [1:0]               rsp_code,
  output logic                     sm_enable,
  output logic [31:0]              sm_vector_length,
  input  logic                     sm_done,
  input  logic                     sm_error,
  input  logic                     fault_clear,
  output logic                     fault,
  output logic                     busy,
  output logic [15:0]              jobs_ok
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESPOND
  } state_t;

  state_t state, state_n;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  hi_id;
  logic [ID_W-1:0]  lo_id;
  logic             hi_found;
  logic             lo_found;
  logic [LEN_W-1:0] win_len;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       code_n;
  logic             take;
  logic             len_bad;
  logic             rsp_load;
  logic             fault_set;

  // Lowest set bit at or above rr_ptr, else lowest set bit overall.
  always_comb begin
    hi_id    = '0;
    lo_id    = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    win_len  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_id    = ID_W'(i);
        lo_found = 1'b1;
        if (ID_W'(i) >= rr_ptr) begin
          hi_id    = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_id = hi_found ? hi_id : lo_id;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        win_len = req_len[i*LEN_W +: LEN_W];
      end
    end
    len_bad = (win_len == '0) ||
              (win_len > LEN_W'(MAX_LEN));
  end

  always_comb begin
    state_n   = state;
    code_n    = 2'b00;
    take      = 1'b0;
    rsp_load  = 1'b0;
    fault_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fault && lo_found) begin
          take = 1'b1;
          if (len_bad) begin
            state_n  = RESPOND;
            code_n   = 2'b01;
            rsp_load = 1'b1;
          end else begin
            state_n = LAUNCH;
          end
        end
      end
      LAUNCH: state_n = BUSY;
      BUSY: begin
        if (sm_error) begin
          state_n   = RESPOND;
          code_n    = 2'b10;
          rsp_load  = 1'b1;
          fault_set = 1'b1;
        end else if (sm_done) begin
          state_n  = RESPOND;
          code_n   = 2'b00;
          rsp_load = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n   = RESPOND;
          code_n    = 2'b11;
          rsp_load  = 1'b1;
          fault_set = 1'b1;
        end
      end
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      id_q             <= '0;
      cnt              <= '0;
      rsp_id           <= '0;
      rsp_code         <= 2'b00;
      sm_vector_length <= '0;
      fault            <= 1'b0;
      jobs_ok          <= '0;
    end else begin
      if (take) id_q <= win_id;
      if (take && !len_bad) begin
        sm_vector_length <= 32'(win_len);
      end
      if (state == LAUNCH) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rsp_load) begin
        rsp_id   <= take ? win_id : id_q;
        rsp_code <= code_n;
      end
      if (fault_set) begin
        fault <= 1'b1;
      end else if (state == IDLE && fault_clear) begin
        fault <= 1'b0;
      end
      if (state == RESPOND) begin
        rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ?
                  '0 : id_q + ID_W'(1);
        if (rsp_code == 2'b00) begin
          jobs_ok <= jobs_ok + 16'd1;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state != IDLE) gnt[id_q] = 1'b1;
  end

  assign sm_enable = (state == LAUNCH);
  assign rsp_valid = (state == RESPOND);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nvdla_softmax_sched.sv
// Directed bench for nvdla_softmax_sched with a per-cycle job model
// and literal checkpoints for the key scenarios.
module tb_nvdla_softmax_sched;

  localparam int N  = 4;
  localparam int LW = 32;
  localparam int ML = 256;
  localparam int TO = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic          sm_done = 1'b0;
  logic          sm_error = 1'b0;
  logic          fault_clear = 1'b0;
  logic [N-1:0]  gnt;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [1:0]    rsp_code;
  logic          sm_enable;
  logic [31:0]   sm_vector_length;
  logic          fault;
  logic          busy;
  logic [15:0]   jobs_ok;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nvdla_softmax_sched #(
    .NUM_REQ(N), .LEN_W(LW), .MAX_LEN(ML),
    .TIMEOUT(TO), .ID_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_len(req_len), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_code(rsp_code), .sm_enable(sm_enable),
    .sm_vector_length(sm_vector_length),
    .sm_done(sm_done), .sm_error(sm_error),
    .fault_clear(fault_clear), .fault(fault),
    .busy(busy), .jobs_ok(jobs_ok)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Job model: phase 0 idle, 1 launch, 2 busy, 3 respond.
  int m_ph = 0, m_own = 0, m_ptr = 0, m_el = 0;
  int m_rid = 0, m_rcode = 0, m_jobs = 0, m_w = 0;
  bit m_fault = 0;
  logic [31:0] m_vlen = '0, m_len = '0;
  logic c_rst, c_done, c_err, c_clr;
  logic [N-1:0] c_req;
  logic [N*LW-1:0] c_len;

  initial forever begin
    @(posedge clk);
    c_rst = rst_n; c_req = req; c_len = req_len;
    c_done = sm_done; c_err = sm_error; c_clr = fault_clear;
    if (!c_rst) begin
      m_ph = 0; m_own = 0; m_ptr = 0; m_el = 0;
      m_rid = 0; m_rcode = 0; m_jobs = 0;
      m_fault = 0; m_vlen = '0;
    end else begin
      case (m_ph)
        0: begin
          if (m_fault) begin
            if (c_clr) m_fault = 0;
          end else if (c_req != '0) begin
            for (int k = 0; k < N; k++) begin
              m_w = (m_ptr + k) % N;
              if (c_req[m_w]) begin
                m_own = m_w;
                break;
              end
            end
            m_len = c_len[m_own*LW +: LW];
            if (m_len == 0 || m_len > ML) begin
              m_ph = 3; m_rid = m_own; m_rcode = 1;
            end else begin
              m_ph = 1; m_vlen = m_len;
            end
          end
        end
        1: begin m_ph = 2; m_el = 0; end
        2: begin
          if (c_err) begin
            m_ph = 3; m_rid = m_own; m_rcode = 2; m_fault = 1;
          end else if (c_done) begin
            m_ph = 3; m_rid = m_own; m_rcode = 0;
          end else if (m_el == TO - 1) begin
            m_ph = 3; m_rid = m_own; m_rcode = 3; m_fault = 1;
          end else begin
            m_el++;
          end
        end
        default: begin
          m_ph = 0;
          m_ptr = (m_own + 1) % N;
          if (m_rcode == 0) m_jobs = (m_jobs + 1) % 65536;
        end
      endcase
    end
    #1;
    chk("gnt", 32'(gnt), (m_ph != 0) ? (32'd1 << m_own) : 32'd0);
    chk("sm_enable", 32'(sm_enable), 32'(m_ph == 1));
    chk("vlen", sm_vector_length, m_vlen);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 3));
    chk("rsp_id", 32'(rsp_id), 32'(m_rid));
    chk("rsp_code", 32'(rsp_code), 32'(m_rcode));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("jobs_ok", 32'(jobs_ok), 32'(m_jobs));
  end

  task automatic set_len(input int i, input int v);
    req_len[i*LW +: LW] = 32'(v);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sm_enable) return;
    end
    chk("enable_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rsp(output int id, output int code,
                          output int cyc, output int ens);
    id = -1; code = -1; cyc = 0; ens = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (sm_enable) ens++;
      if (rsp_valid) begin
        id = int'(rsp_id); code = int'(rsp_code);
        return;
      end
    end
    chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic finish_job(input int d, input bit err,
                            output int id, output int code);
    int cyc, ens;
    repeat (d) @(negedge clk);
    sm_done = 1'b1; sm_error = err;
    wait_rsp(id, code, cyc, ens);
    sm_done = 1'b0; sm_error = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int id, code, cyc, ens, order[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jobs", 32'(jobs_ok), 32'd0);
    rst_n = 1'b1;

    // single job
    set_len(0, 64); req = 4'b0001;
    wait_en();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_vlen", sm_vector_length, 32'd64);
    finish_job(10, 1'b0, id, code);
    chk("single_id", 32'(id), 32'd0);
    chk("single_code", 32'(code), 32'd0);
    req = '0;
    @(negedge clk);
    chk("single_jobs", 32'(jobs_ok), 32'd1);

    // fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 8 * (i + 1));
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_en();
      for (int b = 0; b < N; b++) if (gnt[b]) order.push_back(b);
      finish_job(3, 1'b0, id, code);
    end
    req = '0;
    chk("fair_count", 32'(order.size()), 32'd5);
    for (int j = 0; j < 5 && j < order.size(); j++)
      chk("fair_order", 32'(order[j]), 32'(exp_order[j]));
    @(negedge clk);
    chk("fair_jobs", 32'(jobs_ok), 32'd5);

    // length check
    set_len(2, 0); req = 4'b0100;
    wait_rsp(id, code, cyc, ens);
    req = '0;
    chk("len0_id", 32'(id), 32'd2);
    chk("len0_code", 32'(code), 32'd1);
    chk("len0_en", 32'(ens), 32'd0);
    chk("len0_fault", 32'(fault), 32'd0);
    @(negedge clk);
    set_len(2, 257); req = 4'b0100;
    wait_rsp(id, code, cyc, ens);
    req = '0;
    chk("len257_code", 32'(code), 32'd1);
    chk("len257_en", 32'(ens), 32'd0);
    @(negedge clk);
    set_len(2, 256); set_len(3, 20); req = 4'b1100;
    wait_en();
    chk("ptr3_gnt", 32'(gnt), 32'h8);
    finish_job(2, 1'b0, id, code);
    req = 4'b0100;
    wait_en();
    chk("len256_gnt", 32'(gnt), 32'h4);
    chk("len256_vlen", sm_vector_length, 32'd256);
    finish_job(2, 1'b0, id, code);
    req = '0;

    // engine error with done in the same cycle
    set_len(1, 50); req = 4'b0010;
    wait_en();
    finish_job(4, 1'b1, id, code);
    chk("err_id", 32'(id), 32'd1);
    chk("err_code", 32'(code), 32'd2);
    chk("err_fault", 32'(fault), 32'd1);
    req = 4'b1111;
    ens = 0;
    repeat (8) begin
      @(negedge clk);
      if (sm_enable || gnt != '0) ens++;
    end
    chk("fault_block", 32'(ens), 32'd0);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    chk("fault_clr", 32'(fault), 32'd0);
    wait_en();
    chk("resume_gnt", 32'(gnt), 32'h4);
    finish_job(2, 1'b0, id, code);
    req = '0;

    // timeout
    set_len(3, 10); req = 4'b1000;
    wait_en();
    wait_rsp(id, code, cyc, ens);
    req = '0;
    chk("to_cycles", 32'(cyc), 32'd17);
    chk("to_code", 32'(code), 32'd3);
    chk("to_id", 32'(id), 32'd3);
    chk("to_fault", 32'(fault), 32'd1);
    @(negedge clk);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    set_len(0, 5); req = 4'b0001;
    wait_en();
    finish_job(16, 1'b0, id, code);
    req = '0;
    chk("to_edge_code", 32'(code), 32'd0);
    @(negedge clk);
    chk("to_edge_jobs", 32'(jobs_ok), 32'd9);

    // reset mid-busy
    set_len(1, 30); req = 4'b0010;
    wait_en();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0100;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    ens = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) ens++;
    end
    chk("mid_rst_rsp", 32'(ens), 32'd0);
    rst_n = 1'b1;
    wait_en();
    chk("post_rst_gnt", 32'(gnt), 32'h4);
    finish_job(2, 1'b0, id, code);
    req = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nvdla_softmax_sched.md
Name: nvdla_softmax_sched

Overview:
- Round-robin scheduler that shares one nvdla_softmax engine among NUM_REQ attention-head requesters.
- Each requester posts a row length. The scheduler picks a winner and validates the length.
- It then pulses the engine enable, programs vector_length, and supervises completion, engine error and timeout.
- It returns a per-job status response and holds a sticky fault that blocks new jobs until software clears it.
- It sits between the attention head controllers and the softmax engine. Data movement stays on the engine's own data/out interfaces.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- LEN_W, 32, width of each length field.
- MAX_LEN, 256, largest legal vector length (engine buffer depth).
- TIMEOUT, 60000, number of BUSY cycles before the scheduler declares a hang.
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester job request; level signal, held until the matching response
- req_len  in  NUM_REQ*LEN_W  row length; requester i uses slice [i*LEN_W +: LEN_W]
- gnt  out  NUM_REQ  one-hot grant; high from LAUNCH through RESPOND inclusive
- rsp_valid  out  1  single-cycle job-complete pulse
- rsp_id  out  ID_W  id of the requester that owns the response
- rsp_code  out  2  00=ok, 01=bad length, 10=engine error, 11=timeout
- sm_enable  out  1  engine enable; exactly one-cycle pulse per launched job
- sm_vector_length  out  32  length driven to the engine; zero-extended from LEN_W
- sm_done  in  1  engine completion
- sm_error  in  1  engine error; sticky inside the engine
- fault_clear  in  1  clears the sticky fault; honoured only in IDLE
- fault  out  1  sticky fault flag
- busy  out  1  high in every state except IDLE
- jobs_ok  out  16  count of rsp_code==00 responses; wraps at 0xFFFF→0

Behaviour:
- Reset: state=IDLE and rr_ptr=0. All outputs are 0, including gnt, rsp_valid, rsp_id, rsp_code, sm_enable, sm_vector_length, fault, busy and jobs_ok. Reset asserted mid-job aborts immediately with no response issued.
- States: IDLE, LAUNCH, BUSY, RESPOND.
- IDLE:
  - If fault=0 and any req bit is set, select the winner: the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the winner's id and length.
  - If the length is 0 or >MAX_LEN, go to RESPOND with code 01; no enable is issued and fault is not set.
  - Otherwise go to LAUNCH.
  - If fault=1, no request is accepted.
  - fault_clear=1 in IDLE clears fault the next cycle. A grant can occur the cycle after that.
- LAUNCH (1 cycle): gnt[id]=1, sm_enable=1, sm_vector_length=len, timeout counter cleared, go to BUSY. sm_vector_length holds its value until the next launch.
- BUSY:
  - sm_enable=0 and the counter increments every cycle.
  - sm_error=1 → RESPOND, code 10, set fault. sm_error has priority over sm_done in the same cycle.
  - Else sm_done=1 → RESPOND, code 00. sm_done has priority over a timeout in the same cycle.
  - Else counter==TIMEOUT-1 → RESPOND, code 11, set fault.
- RESPOND (1 cycle):
  - rsp_valid=1 with rsp_id and rsp_code.
  - gnt stays high this cycle and drops when the scheduler returns to IDLE.
  - rr_ptr updates to (id+1) mod NUM_REQ for every code, including 01.
  - jobs_ok increments if code==00.
  - Next state is IDLE.
- Latency: req sampled in IDLE at cycle t → sm_enable at t+1. sm_done at cycle d → rsp_valid at d+1. Minimum IDLE re-arbitration gap is one cycle after RESPOND.
- Requester req deasserting mid-job is ignored; the job completes and responds normally. req_len changing after the IDLE sample has no effect.
- sm_done or sm_error seen in IDLE or LAUNCH is ignored.
- fault_clear outside IDLE is ignored. fault_clear in the same cycle a new fault is set: the set wins.
- rsp_id and rsp_code hold their last value when rsp_valid=0.

Test Plan:
- Single job: req=0001, len=64, sm_done 10 cycles after enable.
  - Expect sm_enable pulse with sm_vector_length=64 and gnt=0001.
  - Expect rsp_valid with id 0, code 00, jobs_ok=1.
- Fairness: req=1111 held, each job completes.
  - Expect grant order 0,1,2,3,0.
  - Expect exactly one sm_enable per job and gnt always one-hot.
- Length check: requester 2 len=0, then len=257.
  - Expect rsp code 01 for id 2 each time, no sm_enable, fault=0, rr_ptr→3.
  - len=256 → launched.
- Engine error: sm_error and sm_done asserted the same cycle in BUSY.
  - Expect code 10 and fault=1; req=1111 gets no grant.
  - fault_clear in IDLE → grant resumes at the next requester.
- Timeout with TIMEOUT=16: sm_done never asserted.
  - Expect rsp code 11 after exactly 16 BUSY cycles and fault=1.
  - sm_done in the cycle the counter hits 15 → code 00 instead.
- Reset mid-BUSY: rst_n low.
  - Expect gnt=0, busy=0 and no rsp_valid.
  - After release, a pending req=0100 is granted (rr_ptr=0 search).
